// File: rtl/stream_upsize_mc.sv
// stream_upsize_mc: multi-channel narrow-to-wide stream packer.
// Each channel accumulates beats into its own word buffer. Completed words
// from all channels share one registered output, granted round-robin.
module stream_upsize_mc #(
  parameter  int T_DATA_WIDTH = 8,
  parameter  int T_DATA_RATIO = 4,
  parameter  int N_CH         = 2,
  localparam int DEST_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic [DEST_W-1:0]       s_dest_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO-1:0],
  output logic [T_DATA_RATIO-1:0] m_keep_o,
  output logic                    m_last_o,
  output logic [DEST_W-1:0]       m_dest_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int                    CNT_W    = $clog2(T_DATA_RATIO);
  localparam int unsigned           NCH_U    = N_CH;
  localparam logic [T_DATA_RATIO-1:0] KEEP_ONE = {{(T_DATA_RATIO-1){1'b0}}, 1'b1};

  // Per-channel state, flattened for the shared output path
  logic [N_CH-1:0]         full;
  logic [N_CH-1:0]         last_v;
  logic [T_DATA_RATIO-1:0] keep_v [N_CH-1:0];
  logic [T_DATA_WIDTH-1:0] lane_v [N_CH-1:0][T_DATA_RATIO-1:0];

  // Arbitration / handshake
  logic                    any_full;
  logic                    load;
  logic                    found;
  logic [DEST_W-1:0]       grant;
  logic [DEST_W-1:0]       idx;
  logic [DEST_W-1:0]       rr_ptr;
  logic                    dest_ok;
  logic                    sel_full;
  logic                    accept;
  logic [T_DATA_WIDTH-1:0] out_lane [T_DATA_RATIO-1:0];

  // Output load condition and round-robin grant, searching from rr_ptr+1
  always_comb begin
    any_full = |full;
    load     = any_full && (!m_valid_o || m_ready_i);
    grant    = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 1; i <= NCH_U; i++) begin
      idx = DEST_W'((32'(rr_ptr) + i) % NCH_U);
      if (!found && full[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // Input ready: blocked only when the target channel holds an unloaded word
  always_comb begin
    dest_ok   = (32'(s_dest_i) < NCH_U);
    sel_full  = dest_ok && full[s_dest_i];
    s_ready_o = !dest_ok || !sel_full || (load && (grant == s_dest_i));
    accept    = s_valid_i && s_ready_o && dest_ok;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0]        cnt_q;
    logic [T_DATA_WIDTH-1:0] lane_q [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0] keep_q;
    logic                    last_q;
    logic                    full_q;
    logic                    wr;
    logic                    clr;
    logic                    done;

    // Decode write/load events for this channel
    always_comb begin
      wr   = accept && (s_dest_i == DEST_W'(g));
      clr  = load && (grant == DEST_W'(g));
      done = (cnt_q == CNT_W'(T_DATA_RATIO - 1)) || s_last_i;
    end

    // Accumulator; a completing write in the load cycle keeps the channel full,
    // and clearing keep on load lets a lane-0 write start a clean word
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        lane_q <= '{default: '0};
        keep_q <= '0;
        last_q <= 1'b0;
        full_q <= 1'b0;
      end else begin
        keep_q <= (clr ? '0 : keep_q) | (wr ? (KEEP_ONE << cnt_q) : '0);
        if (wr) begin
          lane_q[cnt_q] <= s_data_i;
          cnt_q         <= done ? '0 : cnt_q + 1'b1;
        end
        if (wr && done) begin
          full_q <= 1'b1;
          last_q <= s_last_i;
        end else if (clr) begin
          full_q <= 1'b0;
        end
      end
    end

    assign full[g]   = full_q;
    assign last_v[g] = last_q;
    assign keep_v[g] = keep_q;
    assign lane_v[g] = lane_q;
  end

  // Unfilled lanes of the granted word are presented as zero
  for (genvar l = 0; l < T_DATA_RATIO; l++) begin : g_lane
    assign out_lane[l] = keep_v[grant][l] ? lane_v[grant][l] : '0;
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_o <= 1'b0;
      m_data_o  <= '{default: '0};
      m_keep_o  <= '0;
      m_last_o  <= 1'b0;
      m_dest_o  <= '0;
      rr_ptr    <= DEST_W'(N_CH - 1);
    end else if (load) begin
      m_valid_o <= 1'b1;
      m_data_o  <= out_lane;
      m_keep_o  <= keep_v[grant];
      m_last_o  <= last_v[grant];
      m_dest_o  <= grant;
      rr_ptr    <= grant;
    end else if (m_valid_o && m_ready_i) begin
      m_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_upsize_mc.sv
// Directed bench for stream_upsize_mc (4-bit beats, 2 lanes; 2- and 3-channel builds).
module tb_stream_upsize_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Two-channel instance
  logic [3:0] s_data;
  logic [0:0] s_dest;
  logic       s_last, s_valid, s_ready;
  logic [3:0] m_data [1:0];
  logic [1:0] m_keep;
  logic       m_last;
  logic [0:0] m_dest;
  logic       m_valid, m_ready;

  // Three-channel instance
  logic [3:0] s_data3;
  logic [1:0] s_dest3;
  logic       s_last3, s_valid3, s_ready3;
  logic [3:0] m_data3 [1:0];
  logic [1:0] m_keep3;
  logic       m_last3;
  logic [1:0] m_dest3;
  logic       m_valid3, m_ready3;

  int n_cmp = 0;
  int n_err = 0;

  stream_upsize_mc #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2), .N_CH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data), .s_dest_i(s_dest), .s_last_i(s_last),
    .s_valid_i(s_valid), .s_ready_o(s_ready),
    .m_data_o(m_data), .m_keep_o(m_keep), .m_last_o(m_last),
    .m_dest_o(m_dest), .m_valid_o(m_valid), .m_ready_i(m_ready)
  );

  stream_upsize_mc #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2), .N_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data3), .s_dest_i(s_dest3), .s_last_i(s_last3),
    .s_valid_i(s_valid3), .s_ready_o(s_ready3),
    .m_data_o(m_data3), .m_keep_o(m_keep3), .m_last_o(m_last3),
    .m_dest_o(m_dest3), .m_valid_o(m_valid3), .m_ready_i(m_ready3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [0:0] d, input logic [3:0] x, input logic l);
    s_valid = 1'b1;
    s_dest  = d;
    s_data  = x;
    s_last  = l;
  endtask

  task automatic idle;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Word shown as {lane1, lane0}
  task automatic chk_out(input string tag, input logic [7:0] w, input logic [1:0] k,
                         input logic l, input logic [0:0] d);
    chk({tag, ".valid"}, 32'(m_valid), 32'd1);
    chk({tag, ".data"},  32'({m_data[1], m_data[0]}), 32'(w));
    chk({tag, ".keep"},  32'(m_keep), 32'(k));
    chk({tag, ".last"},  32'(m_last), 32'(l));
    chk({tag, ".dest"},  32'(m_dest), 32'(d));
  endtask

  initial begin
    s_data = '0; s_dest = '0; s_last = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    s_data3 = '0; s_dest3 = '0; s_last3 = 1'b0; s_valid3 = 1'b0; m_ready3 = 1'b1;

    // Reset values before any clock edge
    #2;
    chk("rst.valid", 32'(m_valid), 32'd0);
    chk("rst.data",  32'({m_data[1], m_data[0]}), 32'h0);
    chk("rst.keep",  32'(m_keep), 32'd0);
    chk("rst.last",  32'(m_last), 32'd0);
    chk("rst.dest",  32'(m_dest), 32'd0);
    chk("rst.ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single channel: 1, 2, 3(last)
    beat(0, 4'h1, 0); #1 chk("sc.rdy1", 32'(s_ready), 32'd1); tick;
    beat(0, 4'h2, 0); #1 chk("sc.rdy2", 32'(s_ready), 32'd1); tick;
    chk("sc.lat", 32'(m_valid), 32'd0);
    beat(0, 4'h3, 1); #1 chk("sc.rdy3", 32'(s_ready), 32'd1); tick;
    chk_out("sc.w0", 8'h21, 2'b11, 1'b0, 1'b0);
    idle; tick;
    chk_out("sc.w1", 8'h03, 2'b01, 1'b1, 1'b0);
    tick;
    chk("sc.drain", 32'(m_valid), 32'd0);

    // Interleave: ch0 A, ch1 B, ch0 C, ch1 D(last)
    beat(0, 4'hA, 0); tick;
    beat(1, 4'hB, 0); tick;
    beat(0, 4'hC, 0); tick;
    beat(1, 4'hD, 1); tick;
    chk_out("il.w0", 8'hCA, 2'b11, 1'b0, 1'b0);
    idle; tick;
    chk_out("il.w1", 8'hDB, 2'b11, 1'b1, 1'b1);
    tick;
    chk("il.drain", 32'(m_valid), 32'd0);

    // Backpressure
    m_ready = 1'b0;
    beat(0, 4'h1, 0); tick;
    beat(0, 4'h2, 0); tick;
    beat(1, 4'h5, 0); tick;
    chk_out("bp.load", 8'h21, 2'b11, 1'b0, 1'b0);
    beat(1, 4'h6, 0); tick;
    beat(0, 4'h3, 0); tick;
    beat(0, 4'h4, 0); tick;
    chk_out("bp.hold", 8'h21, 2'b11, 1'b0, 1'b0);
    beat(0, 4'h8, 1); #1 chk("bp.stall0", 32'(s_ready), 32'd0);
    tick;
    chk("bp.stall1", 32'(s_ready), 32'd0);
    chk("bp.hold2", 32'({m_data[1], m_data[0]}), 32'h21);
    m_ready = 1'b1; #1 chk("bp.stall2", 32'(s_ready), 32'd0);
    tick;
    chk_out("bp.w1", 8'h65, 2'b11, 1'b0, 1'b1);
    chk("bp.rdy", 32'(s_ready), 32'd1);
    tick;
    chk_out("bp.w2", 8'h43, 2'b11, 1'b0, 1'b0);
    idle; tick;
    chk_out("bp.w3", 8'h08, 2'b01, 1'b1, 1'b0);
    tick;
    chk("bp.drain", 32'(m_valid), 32'd0);

    // Round-robin with both channels pending
    m_ready = 1'b0;
    beat(0, 4'h1, 0); tick;
    beat(0, 4'h2, 0); tick;
    beat(1, 4'h3, 0); tick;
    chk_out("rr.g0", 8'h21, 2'b11, 1'b0, 1'b0);
    beat(1, 4'h4, 0); tick;
    beat(0, 4'h5, 0); tick;
    beat(0, 4'h6, 0); tick;
    m_ready = 1'b1;
    beat(0, 4'h7, 0); #1 chk("rr.rdy0", 32'(s_ready), 32'd0);
    tick;
    chk_out("rr.g1", 8'h43, 2'b11, 1'b0, 1'b1);
    chk("rr.rdy1", 32'(s_ready), 32'd1);
    tick;
    chk_out("rr.g2", 8'h65, 2'b11, 1'b0, 1'b0);
    m_ready = 1'b0;
    beat(0, 4'h8, 0); tick;
    beat(1, 4'h9, 0); tick;
    beat(1, 4'hA, 0); tick;
    chk_out("rr.hold", 8'h65, 2'b11, 1'b0, 1'b0);
    idle; m_ready = 1'b1; tick;
    chk_out("rr.g3", 8'hA9, 2'b11, 1'b0, 1'b1);
    tick;
    chk_out("rr.g4", 8'h87, 2'b11, 1'b0, 1'b0);
    tick;
    chk("rr.drain", 32'(m_valid), 32'd0);

    // Asynchronous reset mid-packet
    m_ready = 1'b0;
    beat(1, 4'h1, 0); tick;
    beat(1, 4'h2, 1); tick;
    beat(0, 4'h7, 0); tick;
    chk_out("ar.pre", 8'h21, 2'b11, 1'b1, 1'b1);
    idle;
    #2 rst_n = 1'b0;
    #1;
    chk("ar.valid", 32'(m_valid), 32'd0);
    chk("ar.data",  32'({m_data[1], m_data[0]}), 32'h0);
    chk("ar.keep",  32'(m_keep), 32'd0);
    chk("ar.last",  32'(m_last), 32'd0);
    chk("ar.dest",  32'(m_dest), 32'd0);
    chk("ar.ready", 32'(s_ready), 32'd1);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    beat(0, 4'h8, 0); tick;
    beat(0, 4'h9, 0); tick;
    idle; tick;
    chk_out("ar.w", 8'h98, 2'b11, 1'b0, 1'b0);
    tick;
    chk("ar.drain", 32'(m_valid), 32'd0);

    // Invalid destination on the three-channel build
    s_valid3 = 1'b1; s_dest3 = 2'd3; s_data3 = 4'h5; s_last3 = 1'b1;
    #1 chk("inv.rdy", 32'(s_ready3), 32'd1);
    tick;
    s_valid3 = 1'b0; tick; tick;
    chk("inv.novalid", 32'(m_valid3), 32'd0);
    s_valid3 = 1'b1; s_dest3 = 2'd2; s_data3 = 4'h6; s_last3 = 1'b1;
    tick;
    s_valid3 = 1'b0; s_last3 = 1'b0; tick;
    chk("inv.valid", 32'(m_valid3), 32'd1);
    chk("inv.data",  32'({m_data3[1], m_data3[0]}), 32'h06);
    chk("inv.keep",  32'(m_keep3), 32'd1);
    chk("inv.last",  32'(m_last3), 32'd1);
    chk("inv.dest",  32'(m_dest3), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
